// File: rtl/mt_thread_sequencer_if.sv
// Fetch-sequencer bus: pipeline control inputs and IF-slot / status outputs.
interface mt_thread_sequencer_if #(
   parameter int NUM_THREADS = 4,
   parameter int PC_W        = 9,
   parameter int CNT_W       = 16
);
   localparam int TW = $clog2(NUM_THREADS);

   logic                   enable;
   logic                   bloom_match;
   logic                   end_of_pkt;
   logic                   redir_mem_valid;
   logic [TW-1:0]          redir_mem_thread;
   logic [PC_W-1:0]        redir_mem_pc;
   logic                   jal_id_valid;
   logic [TW-1:0]          jal_id_thread;
   logic [PC_W-1:0]        jal_id_pc;
   logic                   halt_valid;
   logic [TW-1:0]          halt_thread;
   logic [TW-1:0]          thread_if;
   logic [PC_W-1:0]        pc_out;
   logic                   fetch_valid;
   logic                   armed;
   logic [NUM_THREADS-1:0] thread_active;
   logic                   all_done;
   logic [CNT_W-1:0]       done_count;

   modport master (
      output enable, bloom_match, end_of_pkt,
      output redir_mem_valid, redir_mem_thread, redir_mem_pc,
      output jal_id_valid, jal_id_thread, jal_id_pc,
      output halt_valid, halt_thread,
      input  thread_if, pc_out, fetch_valid, armed, thread_active, all_done, done_count
   );

   modport slave (
      input  enable, bloom_match, end_of_pkt,
      input  redir_mem_valid, redir_mem_thread, redir_mem_pc,
      input  jal_id_valid, jal_id_thread, jal_id_pc,
      input  halt_valid, halt_thread,
      output thread_if, pc_out, fetch_valid, armed, thread_active, all_done, done_count
   );
endinterface

// File: rtl/mt_thread_sequencer.sv
// Round-robin multithreaded fetch sequencer: one PC per thread, redirects,
// per-thread halt, bloom-match arming and packet-completion counting.
module mt_thread_sequencer #(
   parameter int NUM_THREADS   = 4,
   parameter int PC_W          = 9,
   parameter int THREAD_STRIDE = 128,
   parameter int CNT_W         = 16
) (
   input logic                    clk,
   input logic                    rst_bloom,
   mt_thread_sequencer_if.slave   bus
);
   localparam int TW = $clog2(NUM_THREADS);

   typedef logic [PC_W-1:0] pc_t;
   typedef enum logic {ST_IDLE, ST_ARMED} state_t;

   state_t                 state_q, state_d;
   pc_t                    pc_q [NUM_THREADS];
   pc_t                    pc_d [NUM_THREADS];
   logic [TW-1:0]          thread_if_q, thread_if_d;
   logic [NUM_THREADS-1:0] active_q, active_d;
   logic                   all_done_q, all_done_d;
   logic [CNT_W-1:0]       done_count_q, done_count_d;

   function automatic pc_t base_pc(input int t);
      return pc_t'(t * THREAD_STRIDE);
   endfunction

   // Next-state: arming reloads every thread; while running, each live thread
   // takes MEM redirect, then jal, then its own slot increment, unless halted.
   always_comb begin
      state_d      = state_q;
      thread_if_d  = thread_if_q;
      active_d     = active_q;
      all_done_d   = 1'b0;
      done_count_d = done_count_q;
      for (int t = 0; t < NUM_THREADS; t++) begin
         pc_d[t] = pc_q[t];
      end

      if (state_q == ST_IDLE) begin
         if (bus.bloom_match && bus.end_of_pkt) begin
            state_d     = ST_ARMED;
            active_d    = '1;
            thread_if_d = '0;
            for (int t = 0; t < NUM_THREADS; t++) begin
               pc_d[t] = base_pc(t);
            end
         end
      end else if (bus.enable) begin
         thread_if_d = thread_if_q + 1'b1;
         for (int t = 0; t < NUM_THREADS; t++) begin
            if (active_q[t] && !(bus.halt_valid && bus.halt_thread == TW'(t))) begin
               if (bus.redir_mem_valid && bus.redir_mem_thread == TW'(t)) begin
                  pc_d[t] = bus.redir_mem_pc;
               end else if (bus.jal_id_valid && bus.jal_id_thread == TW'(t)) begin
                  pc_d[t] = bus.jal_id_pc;
               end else if (thread_if_q == TW'(t)) begin
                  pc_d[t] = pc_q[t] + 1'b1;
               end
            end
         end
         if (bus.halt_valid) begin
            active_d[bus.halt_thread] = 1'b0;
         end
         if (active_q == '0) begin
            all_done_d = 1'b1;
            state_d    = ST_IDLE;
            if (done_count_q != '1) begin
               done_count_d = done_count_q + 1'b1;
            end
         end
      end
   end

   // State register; reset drops the packet instantly and restores thread bases.
   always_ff @(posedge clk or posedge rst_bloom) begin
      if (rst_bloom) begin
         state_q      <= ST_IDLE;
         thread_if_q  <= '0;
         active_q     <= '0;
         all_done_q   <= 1'b0;
         done_count_q <= '0;
         for (int t = 0; t < NUM_THREADS; t++) begin
            pc_q[t] <= base_pc(t);
         end
      end else begin
         state_q      <= state_d;
         thread_if_q  <= thread_if_d;
         active_q     <= active_d;
         all_done_q   <= all_done_d;
         done_count_q <= done_count_d;
         for (int t = 0; t < NUM_THREADS; t++) begin
            pc_q[t] <= pc_d[t];
         end
      end
   end

   assign bus.thread_if     = thread_if_q;
   assign bus.pc_out        = pc_q[thread_if_q];
   assign bus.armed         = (state_q == ST_ARMED);
   assign bus.fetch_valid   = (state_q == ST_ARMED) && active_q[thread_if_q];
   assign bus.thread_active = active_q;
   assign bus.all_done      = all_done_q;
   assign bus.done_count    = done_count_q;
endmodule
